vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA raster timing generator with a windowed framebuffer viewport, integer pixel replication and read-latency compensation. Runs on the pixel clock, issues framebuffer read addresses, and emits registered sync, data-enable and pixel data that stay aligned for any configured framebuffer read latency. Sits between the game framebuffer/renderer and the board DAC pins. It supersedes the fixed 640x480 driver: every timing is a parameter, sync polarity is selectable, and each frame and line is marked.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- HS_POL, 0, asserted level of vga_hs
- VS_POL, 0, asserted level of vga_vs
- DATA_W, 24, pixel width
- RD_LAT, 1, clocks from x_addr/y_addr to valid pix_data; legal range 0..4
- VP_X0, 0 / VP_Y0, 0: viewport origin in active coordinates
- VP_W, 320 / VP_H, 240: viewport size in framebuffer pixels
- SCALE_SHIFT, 1: each framebuffer pixel is replicated over 2^SCALE_SHIFT clocks and lines
- BG_COLOR, 24'h000000: colour driven inside active video but outside the viewport
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  synchronous run enable
- pix_data  in  DATA_W  framebuffer read data, RD_LAT clocks after its address
- x_addr  out  10  framebuffer column
- y_addr  out  10  framebuffer row
- addr_valid  out  1  x_addr/y_addr reference a pixel inside the viewport
- vga_hs / vga_vs  out  1  sync outputs at the configured polarity
- vga_de  out  1  active video
- vga_rgb  out  DATA_W  pixel out
- frame_start  out  1  one-clock pulse aligned with the first active pixel of a frame
- line_start  out  1  one-clock pulse aligned with the first active pixel of each line

## Operation
- Counters: hc runs 0..H_TOTAL-1 (H_TOTAL = sum of the H parameters). vc advances when hc wraps and runs 0..V_TOTAL-1. There is no extra terminal count.
- Line order is sync, back porch, active, front porch. Sync is asserted while hc < H_SYNC. Active when H_SYNC+H_BP <= hc < H_SYNC+H_BP+H_ACTIVE. Vertical uses the same order.
- Active coordinates: ha = hc - (H_SYNC+H_BP), va likewise.
- Viewport hit: active, VP_X0 <= ha < VP_X0 + (VP_W<<SCALE_SHIFT), and the same test on va.
- On a hit: x_addr = (ha-VP_X0)>>SCALE_SHIFT, y_addr = (va-VP_Y0)>>SCALE_SHIFT, addr_valid = 1. Otherwise x_addr/y_addr = 0 and addr_valid = 0.
- A tag pipeline of depth RD_LAT carries sync, de, hit, frame and line flags. The output register selects pix_data when hit, BG_COLOR when de without hit, and 0 when blanking.
- en low: counters load 0 and the tag pipeline loads "blank / sync inactive". Outputs drain to blank within RD_LAT+1 clocks. en rising starts a fresh frame at hc=vc=0.
- Reset mid-frame: everything returns to reset state immediately. No partial line completes.

## Timing
- Address outputs are combinational from the counters. Stage 0 is the counter value.
- vga_hs, vga_vs, vga_de, vga_rgb, frame_start and line_start are registered. Each reflects the counter state of RD_LAT+1 clocks earlier.
- Reset values: hc = vc = 0, vga_hs = ~HS_POL, vga_vs = ~VS_POL, vga_de = 0, vga_rgb = 0, pulses = 0, addr_valid = 0.
- Boundaries: at hc = H_TOTAL-1, the next clock gives hc = 0 and vc+1. At hc = H_TOTAL-1 with vc = V_TOTAL-1, both wrap to 0.
- When the viewport is clipped by the active edge, the hit test bounds it. Addresses never exceed VP_W-1 / VP_H-1.
- RD_LAT = 0 is legal: pix_data is sampled in the same clock its address is presented.

## Structure
- Shared package vga_pkg holds the 640x480@60 timing constants, an 800x600 set, and a function computing the total from the four segment widths.
- Sub-module vga_axis_counter is instantiated twice (horizontal and vertical). It has parameters ACTIVE/FP/SYNC/BP and inputs step/en, and outputs the count, sync, active, the active coordinate and wrap.

## Test plan
- Defaults, reset released: vga_hs low for exactly 96 clocks of each 800-clock line. vga_vs low for exactly 2 lines of 525, i.e. 1600 clocks. Frame period 420000 clocks.
- Default viewport and RD_LAT=1, with a model framebuffer returning {y,x}: first active pixel gives rgb = {0,0}, x_addr steps every 2 clocks, and the last hit is x_addr=319, y_addr=239.
- VP_X0=100, VP_W=100, SCALE_SHIFT=0: ha = 99 gives BG_COLOR, ha = 100..199 give pix_data, ha = 200 gives BG_COLOR, and rgb = 0 during blanking.
- RD_LAT swept over 0..4: the rising edge of vga_de always coincides with the first valid pixel, and frame_start pulses once per 420000 clocks.
- Assert rst at hc=500, vc=200: all outputs are at reset values in the same clock. After release, frame_start occurs 144+35*800 clocks (+RD_LAT+1) later.
- en low for 1000 clocks mid-line, then high: vga_de stays 0 after the drain, and the following frame timing restarts from hc = vc = 0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants, pipeline tag type and the line/frame length helper
// used by the raster generator and its axis counters.
package vga_pkg;

    localparam int ADDR_W = 10;

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock
    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FP     = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BP     = 48;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FP     = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BP     = 33;

    // 800x600 @ 60 Hz, 40 MHz pixel clock
    localparam int VGA800_H_ACTIVE = 800;
    localparam int VGA800_H_FP     = 40;
    localparam int VGA800_H_SYNC   = 128;
    localparam int VGA800_H_BP     = 88;
    localparam int VGA800_V_ACTIVE = 600;
    localparam int VGA800_V_FP     = 1;
    localparam int VGA800_V_SYNC   = 4;
    localparam int VGA800_V_BP     = 23;

    // Flags that travel alongside a pixel while its framebuffer read is in flight.
    // Sync fields hold "asserted", not the pin level; polarity is applied at the pins.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic hit;
        logic frame;
        logic line;
    } vga_tag_t;

    localparam vga_tag_t TAG_BLANK = vga_tag_t'(6'b000000);

    function automatic int seg_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Framebuffer read port and video output bundle of the VGA timing generator.
interface vga_timing_gen_if
    import vga_pkg::*;
#(
    parameter int DATA_W = 24
);
    logic [ADDR_W-1:0] x_addr;
    logic [ADDR_W-1:0] y_addr;
    logic              addr_valid;
    logic [DATA_W-1:0] pix_data;
    logic              vga_hs;
    logic              vga_vs;
    logic              vga_de;
    logic [DATA_W-1:0] vga_rgb;
    logic              frame_start;
    logic              line_start;

    modport master (
        output x_addr, y_addr, addr_valid,
        input  pix_data,
        output vga_hs, vga_vs, vga_de, vga_rgb, frame_start, line_start
    );

    modport slave (
        input  x_addr, y_addr, addr_valid,
        output pix_data,
        input  vga_hs, vga_vs, vga_de, vga_rgb, frame_start, line_start
    );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter ordered sync, back porch, active, front porch,
// with region decode and the coordinate relative to the first active position.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter int CNT_W  = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             step,
    output logic [CNT_W-1:0] cnt,
    output logic             sync,
    output logic             active,
    output logic [CNT_W-1:0] coord,
    output logic             wrap
);
    localparam int TOTAL = seg_total(ACTIVE, FP, SYNC, BP);
    localparam logic [CNT_W-1:0] LAST      = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] SYNC_END  = CNT_W'(SYNC);
    localparam logic [CNT_W-1:0] ACT_START = CNT_W'(SYNC + BP);
    localparam logic [CNT_W-1:0] ACT_END   = CNT_W'(SYNC + BP + ACTIVE);

    logic [CNT_W-1:0] cnt_r;

    // Region decode and wrap detection from the current position.
    always_comb begin
        cnt    = cnt_r;
        wrap   = en && step && (cnt_r == LAST);
        sync   = (cnt_r < SYNC_END);
        active = (cnt_r >= ACT_START) && (cnt_r < ACT_END);
        coord  = cnt_r - ACT_START;
    end

    // Position register; held at zero while disabled so a restart begins a fresh frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (!en || wrap) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (step) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end
endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: windowed, pixel-replicated framebuffer viewport with the
// sync/enable tags delayed to match the framebuffer read latency.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE    = VGA640_H_ACTIVE,
    parameter int H_FP        = VGA640_H_FP,
    parameter int H_SYNC      = VGA640_H_SYNC,
    parameter int H_BP        = VGA640_H_BP,
    parameter int V_ACTIVE    = VGA640_V_ACTIVE,
    parameter int V_FP        = VGA640_V_FP,
    parameter int V_SYNC      = VGA640_V_SYNC,
    parameter int V_BP        = VGA640_V_BP,
    parameter logic HS_POL    = 1'b0,
    parameter logic VS_POL    = 1'b0,
    parameter int DATA_W      = 24,
    parameter int RD_LAT      = 1,
    parameter int VP_X0       = 0,
    parameter int VP_Y0       = 0,
    parameter int VP_W        = 320,
    parameter int VP_H        = 240,
    parameter int SCALE_SHIFT = 1,
    parameter logic [DATA_W-1:0] BG_COLOR = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    vga_timing_gen_if.master  bus
);
    localparam int CNT_W    = 12;
    localparam int VP_W_CLK = VP_W << SCALE_SHIFT;
    localparam int VP_H_CLK = VP_H << SCALE_SHIFT;
    localparam logic [CNT_W-1:0] H_ACT_START = CNT_W'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] V_ACT_START = CNT_W'(V_SYNC + V_BP);

    logic [CNT_W-1:0]  h_cnt_s, h_coord_s, v_cnt_s, v_coord_s;
    logic              h_sync_s, h_active_s, h_wrap_s;
    logic              v_sync_s, v_active_s, unused_v_wrap_s;
    int                h_rel_s, v_rel_s;
    logic              hit_s;
    logic [ADDR_W-1:0] x_addr_s, y_addr_s;
    vga_tag_t          tag_s, tag_in_s, tag_out_s;
    logic [DATA_W-1:0] rgb_next_s;
    logic              hs_r, vs_r, de_r, frame_r, line_r;
    logic [DATA_W-1:0] rgb_r;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CNT_W(CNT_W)
    ) u_h_cnt (
        .clk(clk), .rst(rst), .en(en), .step(1'b1),
        .cnt(h_cnt_s), .sync(h_sync_s), .active(h_active_s), .coord(h_coord_s), .wrap(h_wrap_s)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CNT_W(CNT_W)
    ) u_v_cnt (
        .clk(clk), .rst(rst), .en(en), .step(h_wrap_s),
        .cnt(v_cnt_s), .sync(v_sync_s), .active(v_active_s), .coord(v_coord_s), .wrap(unused_v_wrap_s)
    );

    // Viewport hit and framebuffer address; signed offsets keep the window test exact at any origin.
    always_comb begin
        h_rel_s = int'(h_coord_s) - VP_X0;
        v_rel_s = int'(v_coord_s) - VP_Y0;
        hit_s   = h_active_s && v_active_s &&
                  (h_rel_s >= 0) && (h_rel_s < VP_W_CLK) &&
                  (v_rel_s >= 0) && (v_rel_s < VP_H_CLK);
        if (hit_s) begin
            x_addr_s = ADDR_W'(h_rel_s >>> SCALE_SHIFT);
            y_addr_s = ADDR_W'(v_rel_s >>> SCALE_SHIFT);
        end else begin
            x_addr_s = {ADDR_W{1'b0}};
            y_addr_s = {ADDR_W{1'b0}};
        end
    end

    assign bus.x_addr     = x_addr_s;
    assign bus.y_addr     = y_addr_s;
    assign bus.addr_valid = hit_s;

    // Stage-0 tag from the counters, forced blank while the generator is disabled.
    always_comb begin
        tag_s       = TAG_BLANK;
        tag_s.hs    = h_sync_s;
        tag_s.vs    = v_sync_s;
        tag_s.de    = h_active_s && v_active_s;
        tag_s.hit   = hit_s;
        tag_s.line  = h_active_s && v_active_s && (h_cnt_s == H_ACT_START);
        tag_s.frame = h_active_s && v_active_s && (h_cnt_s == H_ACT_START) && (v_cnt_s == V_ACT_START);
        if (en) begin
            tag_in_s = tag_s;
        end else begin
            tag_in_s = TAG_BLANK;
        end
    end

    if (RD_LAT == 0) begin : g_no_lat
        assign tag_out_s = tag_in_s;
    end else begin : g_lat
        vga_tag_t pipe_r [RD_LAT];

        // Delay line matching the framebuffer read latency.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < RD_LAT; i++) begin
                    pipe_r[i] <= TAG_BLANK;
                end
            end else begin
                pipe_r[0] <= tag_in_s;
                for (int i = 1; i < RD_LAT; i++) begin
                    pipe_r[i] <= pipe_r[i-1];
                end
            end
        end

        assign tag_out_s = pipe_r[RD_LAT-1];
    end

    // Pixel source select for the tag leaving the delay line.
    always_comb begin
        if (tag_out_s.hit) begin
            rgb_next_s = bus.pix_data;
        end else if (tag_out_s.de) begin
            rgb_next_s = BG_COLOR;
        end else begin
            rgb_next_s = {DATA_W{1'b0}};
        end
    end

    // Output register driving the DAC pins and the frame/line markers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_r    <= ~HS_POL;
            vs_r    <= ~VS_POL;
            de_r    <= 1'b0;
            rgb_r   <= {DATA_W{1'b0}};
            frame_r <= 1'b0;
            line_r  <= 1'b0;
        end else begin
            hs_r    <= tag_out_s.hs ? HS_POL : ~HS_POL;
            vs_r    <= tag_out_s.vs ? VS_POL : ~VS_POL;
            de_r    <= tag_out_s.de;
            rgb_r   <= rgb_next_s;
            frame_r <= tag_out_s.frame;
            line_r  <= tag_out_s.line;
        end
    end

    assign bus.vga_hs      = hs_r;
    assign bus.vga_vs      = vs_r;
    assign bus.vga_de      = de_r;
    assign bus.vga_rgb     = rgb_r;
    assign bus.frame_start = frame_r;
    assign bus.line_start  = line_r;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced 16x8 raster (25x13 clocks): five read latencies
// with a full-screen 2x viewport, plus a clipped 1x window with inverted sync polarity.
module tb_vga_timing_gen;
    localparam int HT   = 25;
    localparam int FT   = 325;
    localparam int FS_T = 107;
    localparam int NI   = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;

    int total = 0;
    int bad   = 0;

    logic        de_a [NI];
    logic        hs_a [NI];
    logic        vs_a [NI];
    logic        fs_a [NI];
    logic        ls_a [NI];
    logic        av_a [NI];
    logic [23:0] rgb_a [NI];
    logic [9:0]  xa_a [NI];
    logic [9:0]  ya_a [NI];

    int tcnt;
    int hist [5];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int   LAT = (g == 5) ? 2 : g;
        localparam int   X0  = (g == 5) ? 5 : 0;
        localparam int   Y0  = (g == 5) ? 6 : 0;
        localparam int   W   = (g == 5) ? 6 : 8;
        localparam int   SH  = (g == 5) ? 0 : 1;
        localparam logic [23:0] BG = (g == 5) ? 24'hABCDEF : 24'h123456;
        localparam logic POL = (g == 5) ? 1'b1 : 1'b0;

        vga_timing_gen_if #(.DATA_W(24)) ifc ();
        logic [23:0] fb_s;

        vga_timing_gen #(
            .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
            .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2),
            .HS_POL(POL), .VS_POL(POL), .DATA_W(24), .RD_LAT(LAT),
            .VP_X0(X0), .VP_Y0(Y0), .VP_W(W), .VP_H(4), .SCALE_SHIFT(SH), .BG_COLOR(BG)
        ) u_dut (
            .clk(clk), .rst(rst), .en(en), .bus(ifc)
        );

        assign fb_s = {4'h0, ifc.y_addr, ifc.x_addr};
        if (LAT == 0) begin : g_fb0
            assign ifc.pix_data = fb_s;
        end else begin : g_fb
            logic [23:0] d_r [LAT];
            always @(posedge clk) begin
                d_r[0] <= fb_s;
                for (int i = 1; i < LAT; i++) d_r[i] <= d_r[i-1];
            end
            assign ifc.pix_data = d_r[LAT-1];
        end

        assign de_a[g]  = ifc.vga_de;
        assign hs_a[g]  = ifc.vga_hs;
        assign vs_a[g]  = ifc.vga_vs;
        assign fs_a[g]  = ifc.frame_start;
        assign ls_a[g]  = ifc.line_start;
        assign av_a[g]  = ifc.addr_valid;
        assign rgb_a[g] = ifc.vga_rgb;
        assign xa_a[g]  = ifc.x_addr;
        assign ya_a[g]  = ifc.y_addr;
    end

    // Raster position presented before each edge, and its history for latency alignment.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt <= 0;
            for (int k = 0; k < 5; k++) hist[k] <= -1;
        end else begin
            hist[0] <= en ? tcnt : -1;
            for (int k = 1; k < 5; k++) hist[k] <= hist[k-1];
            tcnt <= (!en || tcnt == FT - 1) ? 0 : tcnt + 1;
        end
    end

    function automatic void cfg(input int i, output int lat, output int x0, output int y0,
                                output int w, output int sh, output logic [23:0] bg, output logic pol);
        if (i == 5) begin
            lat = 2; x0 = 5; y0 = 6; w = 6; sh = 0; bg = 24'hABCDEF; pol = 1'b1;
        end else begin
            lat = i; x0 = 0; y0 = 0; w = 8; sh = 1; bg = 24'h123456; pol = 1'b0;
        end
    endfunction

    // Expected pins for instance i given the raster position s (-1 = blank tag).
    function automatic void model(input int i, input int s, output logic hs, output logic vs,
                                  output logic de, output logic fs, output logic ls, output logic [23:0] rgb);
        int lat, x0, y0, w, sh, hc, vc, ha, va;
        logic [23:0] bg;
        logic pol, hit;
        logic [9:0] xv, yv;
        cfg(i, lat, x0, y0, w, sh, bg, pol);
        hs = ~pol; vs = ~pol; de = 1'b0; fs = 1'b0; ls = 1'b0; rgb = 24'h0;
        if (s >= 0) begin
            hc = s % HT; vc = s / HT;
            ha = hc - 7; va = vc - 4;
            if (hc < 3) hs = pol;
            if (vc < 2) vs = pol;
            de  = (ha >= 0) && (ha < 16) && (va >= 0) && (va < 8);
            ls  = de && (ha == 0);
            fs  = ls && (va == 0);
            hit = de && (ha >= x0) && (ha < x0 + (w << sh)) && (va >= y0) && (va < y0 + (4 << sh));
            xv  = 10'((ha - x0) >>> sh);
            yv  = 10'((va - y0) >>> sh);
            if (hit) rgb = {4'h0, yv, xv};
            else if (de) rgb = bg;
        end
    endfunction

    task automatic wait_state(input int target, input int depth, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 2 * FT; n++) begin
            @(negedge clk);
            if ((depth < 0 ? tcnt : hist[depth]) == target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int lat, x0, y0, w, sh;
        logic [23:0] bg;
        logic pol;
        rst = 1'b1; en = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            cfg(i, lat, x0, y0, w, sh, bg, pol);
            total += 4;
            if (hs_a[i] !== ~pol || vs_a[i] !== ~pol) begin
                bad++; $display("FAIL reset_sync[%0d] hs=%b vs=%b want %b", i, hs_a[i], vs_a[i], ~pol);
            end
            if (de_a[i] !== 1'b0 || rgb_a[i] !== 24'h0) begin
                bad++; $display("FAIL reset_video[%0d] de=%b rgb=%h want 0/000000", i, de_a[i], rgb_a[i]);
            end
            if (fs_a[i] !== 1'b0 || ls_a[i] !== 1'b0) begin
                bad++; $display("FAIL reset_pulse[%0d] fs=%b ls=%b want 0", i, fs_a[i], ls_a[i]);
            end
            if (av_a[i] !== 1'b0 || xa_a[i] !== 10'd0 || ya_a[i] !== 10'd0) begin
                bad++; $display("FAIL reset_addr[%0d] av=%b x=%0d y=%0d want 0", i, av_a[i], xa_a[i], ya_a[i]);
            end
        end
        rst = 1'b0; en = 1'b1;
    endtask

    task automatic test_sync_counts();
        int lat, x0, y0, w, sh;
        logic [23:0] bg;
        logic pol;
        int hs_n [NI], vs_n [NI], de_n [NI], fs_n [NI], ls_n [NI];
        repeat (10) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            hs_n[i] = 0; vs_n[i] = 0; de_n[i] = 0; fs_n[i] = 0; ls_n[i] = 0;
        end
        for (int c = 0; c < FT; c++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                cfg(i, lat, x0, y0, w, sh, bg, pol);
                if (hs_a[i] === pol) hs_n[i]++;
                if (vs_a[i] === pol) vs_n[i]++;
                if (de_a[i] === 1'b1) de_n[i]++;
                if (fs_a[i] === 1'b1) fs_n[i]++;
                if (ls_a[i] === 1'b1) ls_n[i]++;
            end
        end
        for (int i = 0; i < NI; i++) begin
            total += 5;
            if (hs_n[i] !== 39) begin bad++; $display("FAIL hs_count[%0d] got %0d want 39", i, hs_n[i]); end
            if (vs_n[i] !== 50) begin bad++; $display("FAIL vs_count[%0d] got %0d want 50", i, vs_n[i]); end
            if (de_n[i] !== 128) begin bad++; $display("FAIL de_count[%0d] got %0d want 128", i, de_n[i]); end
            if (fs_n[i] !== 1) begin bad++; $display("FAIL fs_count[%0d] got %0d want 1", i, fs_n[i]); end
            if (ls_n[i] !== 8) begin bad++; $display("FAIL ls_count[%0d] got %0d want 8", i, ls_n[i]); end
        end
    endtask

    task automatic test_frame_period();
        int n;
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 2 * FT && !seen; c++) begin
            @(negedge clk);
            if (fs_a[3] === 1'b1) seen = 1'b1;
        end
        n = 0;
        if (seen) begin
            for (int c = 1; c <= 2 * FT; c++) begin
                @(negedge clk);
                if (fs_a[3] === 1'b1) begin n = c; break; end
            end
        end
        total++;
        if (n !== FT) begin bad++; $display("FAIL frame_period got %0d want %0d", n, FT); end
    endtask

    task automatic test_pixel_stream(input int ncyc);
        int lat, x0, y0, w, sh;
        logic [23:0] bg, e_rgb;
        logic pol, e_hs, e_vs, e_de, e_fs, e_ls;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                cfg(i, lat, x0, y0, w, sh, bg, pol);
                model(i, hist[lat], e_hs, e_vs, e_de, e_fs, e_ls, e_rgb);
                total++;
                if ({hs_a[i], vs_a[i], de_a[i], fs_a[i], ls_a[i]} !== {e_hs, e_vs, e_de, e_fs, e_ls}) begin
                    bad++;
                    $display("FAIL stream_ctl[%0d] s=%0d hs/vs/de/fs/ls=%b%b%b%b%b want %b%b%b%b%b", i, hist[lat],
                             hs_a[i], vs_a[i], de_a[i], fs_a[i], ls_a[i], e_hs, e_vs, e_de, e_fs, e_ls);
                end
                total++;
                if (rgb_a[i] !== e_rgb) begin
                    bad++; $display("FAIL stream_rgb[%0d] s=%0d got %h want %h", i, hist[lat], rgb_a[i], e_rgb);
                end
            end
        end
    endtask

    task automatic test_addresses();
        bit ok;
        int tgt [8] = '{107, 108, 109, 261, 262, 267, 268, 287};
        int xe1 [8] = '{0, 0, 1, 2, 2, 5, 5, 2};
        int ye5 [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
        bit v5  [8] = '{0, 0, 0, 0, 1, 1, 0, 1};
        int xe5 [8] = '{0, 0, 0, 0, 0, 5, 0, 0};
        for (int k = 0; k < 8; k++) begin
            wait_state(tgt[k], -1, ok);
            total++;
            if (!ok) begin bad++; $display("FAIL addr_wait state %0d not reached", tgt[k]); end
            total += 2;
            if (av_a[1] !== 1'b1 || xa_a[1] !== 10'(xe1[k])) begin
                bad++; $display("FAIL addr_full s=%0d av=%b x=%0d want 1/%0d", tgt[k], av_a[1], xa_a[1], xe1[k]);
            end
            if (av_a[5] !== v5[k] || xa_a[5] !== 10'(xe5[k]) || ya_a[5] !== 10'(v5[k] ? ye5[k] : 0)) begin
                bad++; $display("FAIL addr_win s=%0d av=%b x=%0d y=%0d want %b/%0d/%0d", tgt[k],
                                av_a[5], xa_a[5], ya_a[5], v5[k], xe5[k], v5[k] ? ye5[k] : 0);
            end
        end
        wait_state(11 * HT + 22, -1, ok);
        total++;
        if (!ok || av_a[1] !== 1'b1 || xa_a[1] !== 10'd7 || ya_a[1] !== 10'd3) begin
            bad++; $display("FAIL addr_last av=%b x=%0d y=%0d want 1/7/3", av_a[1], xa_a[1], ya_a[1]);
        end
        @(negedge clk);
        total++;
        if (av_a[1] !== 1'b0 || xa_a[1] !== 10'd0) begin
            bad++; $display("FAIL addr_after_last av=%b x=%0d want 0/0", av_a[1], xa_a[1]);
        end
    endtask

    task automatic test_window_pixels();
        bit ok;
        int          tgt [6] = '{250, 261, 262, 267, 268, 287};
        logic [23:0] exp_rgb [6] = '{24'h000000, 24'hABCDEF, 24'h000000, 24'h000005, 24'hABCDEF, 24'h000400};
        logic        exp_de [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int k = 0; k < 6; k++) begin
            wait_state(tgt[k], 2, ok);
            total++;
            if (!ok || rgb_a[5] !== exp_rgb[k] || de_a[5] !== exp_de[k]) begin
                bad++; $display("FAIL window s=%0d rgb=%h de=%b want %h/%b", tgt[k], rgb_a[5], de_a[5], exp_rgb[k], exp_de[k]);
            end
        end
        wait_state(1, 2, ok);
        total++;
        if (!ok || hs_a[5] !== 1'b1 || vs_a[5] !== 1'b1 || hs_a[2] !== 1'b0) begin
            bad++; $display("FAIL sync_pol hs5=%b vs5=%b hs2=%b want 1/1/0", hs_a[5], vs_a[5], hs_a[2]);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int lat, x0, y0, w, sh;
        logic [23:0] bg;
        logic pol;
        int first [NI];
        wait_state(7 * HT + 15, -1, ok);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) begin
            cfg(i, lat, x0, y0, w, sh, bg, pol);
            total++;
            if (hs_a[i] !== ~pol || vs_a[i] !== ~pol || de_a[i] !== 1'b0 || rgb_a[i] !== 24'h0 ||
                fs_a[i] !== 1'b0 || ls_a[i] !== 1'b0 || av_a[i] !== 1'b0) begin
                bad++; $display("FAIL mid_reset[%0d] hs=%b vs=%b de=%b rgb=%h av=%b", i,
                                hs_a[i], vs_a[i], de_a[i], rgb_a[i], av_a[i]);
            end
            first[i] = -1;
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++)
                if (first[i] < 0 && fs_a[i] === 1'b1) first[i] = k;
        end
        for (int i = 0; i < NI; i++) begin
            cfg(i, lat, x0, y0, w, sh, bg, pol);
            total++;
            if (first[i] !== FS_T + lat + 1) begin
                bad++; $display("FAIL reset_fs[%0d] got %0d want %0d", i, first[i], FS_T + lat + 1);
            end
        end
    endtask

    task automatic test_en_low();
        bit ok;
        int lat, x0, y0, w, sh;
        logic [23:0] bg;
        logic pol;
        int first [NI];
        int rise [NI];
        wait_state(5 * HT + 12, -1, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL en_wait state not reached"); end
        en = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                cfg(i, lat, x0, y0, w, sh, bg, pol);
                if (c >= lat + 1) begin
                    total++;
                    if (de_a[i] !== 1'b0 || rgb_a[i] !== 24'h0 || hs_a[i] !== ~pol) begin
                        bad++; $display("FAIL en_drain[%0d] c=%0d de=%b rgb=%h hs=%b", i, c, de_a[i], rgb_a[i], hs_a[i]);
                    end
                end
            end
        end
        en = 1'b1;
        for (int i = 0; i < NI; i++) begin first[i] = -1; rise[i] = -1; end
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if (first[i] < 0 && fs_a[i] === 1'b1) first[i] = k;
                if (rise[i] < 0 && de_a[i] === 1'b1) rise[i] = k;
            end
        end
        for (int i = 0; i < NI; i++) begin
            cfg(i, lat, x0, y0, w, sh, bg, pol);
            total++;
            if (first[i] !== FS_T + lat + 1 || rise[i] !== FS_T + lat + 1) begin
                bad++; $display("FAIL en_restart[%0d] fs=%0d de_rise=%0d want %0d", i, first[i], rise[i], FS_T + lat + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sync_counts();
        test_frame_period();
        test_pixel_stream(FT + 5);
        test_addresses();
        test_window_pixels();
        test_reset_mid();
        test_en_low();
        test_pixel_stream(60);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
